data_bus_buffer_fifo: RTL and testbench

- Parametrised, clocked successor to the 8259 data bus buffer.
- Connects the external bidirectional CPU data bus to internal PIC logic.
- Write path: CPU writes (w strobe) are edge-detected and queued in a DEPTH-entry FIFO, then handed to internal logic with a valid/ready handshake.
- Read path: CPU reads (r strobe) latch internal read data into a holding register, which drives the bus for the whole strobe. Overflow and r/w conflicts are reported as sticky errors.

---
 rtl/data_bus_buffer_fifo.sv | 143 ++++++++++++++
 tb/tb_data_bus_buffer_fifo.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_buffer_fifo.sv
// CPU data bus buffer: synchronised r/w strobes, a write FIFO toward the PIC core,
// and a per-strobe latched read-back register driving the bidirectional bus.
module data_bus_buffer_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  inout  wire  [WIDTH-1:0]       data,
  input  logic                   r,
  input  logic                   w,
  output logic [WIDTH-1:0]       wr_data,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  input  logic [WIDTH-1:0]       rd_data,
  output logic                   rd_ack,
  output logic [$clog2(DEPTH):0] level,
  output logic [1:0]             err,
  input  logic                   err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  logic             r_s;
  logic             w_s;
  logic [WIDTH-1:0] data_s;

  // The bus value travels through the same number of flops as the strobes so
  // a push captures the word that was present when w was seen.
  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign r_s    = r;
      assign w_s    = w;
      assign data_s = data;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync_reg;
      logic [SYNC_STAGES-1:0] w_sync_reg;
      logic [WIDTH-1:0]       data_sync_reg [SYNC_STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync_reg <= '0;
          w_sync_reg <= '0;
          for (int i = 0; i < SYNC_STAGES; i++) data_sync_reg[i] <= '0;
        end else begin
          r_sync_reg[0]    <= r;
          w_sync_reg[0]    <= w;
          data_sync_reg[0] <= data;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync_reg[i]    <= r_sync_reg[i-1];
            w_sync_reg[i]    <= w_sync_reg[i-1];
            data_sync_reg[i] <= data_sync_reg[i-1];
          end
        end
      end

      assign r_s    = r_sync_reg[SYNC_STAGES-1];
      assign w_s    = w_sync_reg[SYNC_STAGES-1];
      assign data_s = data_sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic             r_prev_reg;
  logic             w_prev_reg;
  logic             r_rise;
  logic             w_rise;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_reg;
  logic [AW:0]      wptr_next;
  logic [AW:0]      rptr_reg;
  logic [AW:0]      rptr_next;
  logic [1:0]       err_reg;
  logic [1:0]       err_next;
  logic [WIDTH-1:0] hold_reg;
  logic             rd_active_reg;
  logic             rd_active_next;
  logic             full;
  logic             pop;
  logic             push_req;
  logic             push_ok;
  logic             overflow;
  logic             conflict;
  logic             bus_oe;

  assign r_rise = r_s & ~r_prev_reg;
  assign w_rise = w_s & ~w_prev_reg;

  assign level    = wptr_reg - rptr_reg;
  assign wr_valid = (level != '0);
  assign full     = (level == FULL_LEVEL);
  assign pop      = wr_valid & wr_ready;
  assign push_req = w_rise & ~r_s;
  // A simultaneous pop frees the slot, so a full FIFO can still accept the push.
  assign push_ok  = push_req & (~full | pop);
  assign overflow = push_req & full & ~pop;
  assign conflict = (w_rise & r_s) | (r_rise & w_s);
  assign wr_data  = wr_valid ? mem[rptr_reg[AW-1:0]] : '0;

  assign rd_ack = r_rise & ~rst;
  assign bus_oe = rd_active_reg & r_s;
  assign data   = bus_oe ? hold_reg : {WIDTH{1'bz}};
  assign err    = err_reg;

  always_comb begin
    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    err_next       = err_reg;
    rd_active_next = r_s & (rd_active_reg | r_rise);
    if (push_ok) wptr_next = wptr_reg + PTR_ONE;
    if (pop)     rptr_next = rptr_reg + PTR_ONE;
    // Clear first so an error event in the same cycle keeps its bit set.
    if (err_clr)  err_next    = 2'b00;
    if (overflow) err_next[0] = 1'b1;
    if (conflict) err_next[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      err_reg       <= 2'b00;
      hold_reg      <= '0;
      rd_active_reg <= 1'b0;
      r_prev_reg    <= 1'b0;
      w_prev_reg    <= 1'b0;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      err_reg       <= err_next;
      rd_active_reg <= rd_active_next;
      r_prev_reg    <= r_s;
      w_prev_reg    <= w_s;
      if (r_rise) hold_reg <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wptr_reg[AW-1:0]] <= data_s;
  end

endmodule

// File: tb/tb_data_bus_buffer_fifo.sv
// Scenario bench for data_bus_buffer_fifo: queue-based reference model of the
// write path, per-strobe read expectations, pullup on the bus to observe release.
module tb_data_bus_buffer_fifo;
  localparam int WIDTH       = 8;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam logic [7:0] BUS_IDLE = 8'hFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       r;
  logic       w;
  logic       wr_ready;
  logic       err_clr;
  logic       rd_ack;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [2:0] level;
  logic [1:0] err;
  logic [7:0] tb_drv;
  logic       tb_oe;
  wire  [7:0] data;

  assign data = tb_oe ? tb_drv : 8'hzz;
  pullup pu_data (data);

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] model_q [$];
  logic [1:0] model_err;

  data_bus_buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .data(data), .r(r), .w(w),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_ack(rd_ack), .level(level), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected simulation end");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // CPU write cycle; the model applies the FIFO rules to the same event.
  task automatic cpu_write(input logic [7:0] v, input bit clr_at_push, input bit pop_at_push);
    bit was_full;
    was_full = (model_q.size() == DEPTH);
    tb_drv = v; tb_oe = 1'b1; w = 1'b1;
    step(2);
    if (clr_at_push) err_clr = 1'b1;
    if (pop_at_push) wr_ready = 1'b1;
    step(1);
    err_clr = 1'b0; wr_ready = 1'b0;
    step(1);
    w = 1'b0;
    step(3);
    tb_oe = 1'b0;
    if (pop_at_push && model_q.size() > 0) void'(model_q.pop_front());
    if (clr_at_push) model_err = 2'b00;
    if (!was_full || pop_at_push) model_q.push_back(v);
    else model_err[0] = 1'b1;
    $display("[TB] write %h level=%0d err=%b", v, level, err);
  endtask

  task automatic cpu_read(input logic [7:0] v, input logic [7:0] v2, input int hold,
                          output int acks, output int ack_cycle, output logic [7:0] bus_at_ack,
                          output logic [7:0] bus_first, output logic [7:0] bus_last,
                          output logic [7:0] bus_after);
    acks = 0; ack_cycle = -1; bus_at_ack = 8'h00; bus_first = 8'h00;
    rd_data = v; r = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      step(1);
      if (rd_ack) begin
        acks++;
        if (ack_cycle < 0) begin ack_cycle = i; bus_at_ack = data; end
      end
      if (ack_cycle > 0 && i == ack_cycle + 1) begin bus_first = data; rd_data = v2; end
    end
    bus_last = data;
    r = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (rd_ack) acks++;
    end
    bus_after = data;
    $display("[TB] read latched %h acks=%0d bus_after=%h", v, acks, bus_after);
  endtask

  task automatic test_reset;
    int acks;
    rst = 1'b1; r = 1'b0; w = 1'b0; wr_ready = 1'b0; err_clr = 1'b0;
    tb_oe = 1'b0; tb_drv = 8'h00; rd_data = 8'h00;
    step(2);
    rst = 1'b0;
    model_q.delete(); model_err = 2'b00;
    acks = 0;
    for (int i = 0; i < 8; i++) begin step(1); if (rd_ack) acks++; end
    tests_run++; if (data !== BUS_IDLE) begin tests_failed++; $display("FAIL reset_bus: got %h expected %h", data, BUS_IDLE); end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL reset_level: got %0d expected 0", level); end
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
    tests_run++; if (wr_data !== 8'h00) begin tests_failed++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
    tests_run++; if (err !== 2'b00) begin tests_failed++; $display("FAIL reset_err: got %b expected 00", err); end
    tests_run++; if (acks !== 0) begin tests_failed++; $display("FAIL reset_rd_ack: got %0d pulses expected 0", acks); end
    $display("[TB] reset done");
  endtask

  task automatic test_fifo_order;
    wr_ready = 1'b0;
    tb_drv = 8'hAA; tb_oe = 1'b1; w = 1'b1;
    step(2);
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL no_bypass: got wr_valid=%b expected 0", wr_valid); end
    step(1);
    tests_run++; if (wr_valid !== 1'b1) begin tests_failed++; $display("FAIL push_latency: got wr_valid=%b expected 1", wr_valid); end
    tests_run++; if (wr_data !== 8'hAA) begin tests_failed++; $display("FAIL push_word: got %h expected aa", wr_data); end
    step(1); w = 1'b0; step(3); tb_oe = 1'b0;
    model_q.push_back(8'hAA);
    $display("[TB] write aa level=%0d", level);
    cpu_write(8'h11, 1'b0, 1'b0);
    cpu_write(8'h55, 1'b0, 1'b0);
    tests_run++; if (level !== 3'(model_q.size())) begin tests_failed++; $display("FAIL order_level: got %0d expected %0d", level, model_q.size()); end
    wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (wr_data !== model_q[0]) begin tests_failed++; $display("FAIL pop_order[%0d]: got %h expected %h", i, wr_data, model_q[0]); end
      step(1);
      $display("[TB] pop %h", model_q[0]);
      void'(model_q.pop_front());
    end
    wr_ready = 1'b0;
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL drained_valid: got %b expected 0", wr_valid); end
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL drained_level: got %0d expected 0", level); end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 5; i++) cpu_write(8'(i), 1'b0, 1'b0);
    tests_run++; if (level !== 3'(model_q.size())) begin tests_failed++; $display("FAIL ovf_level: got %0d expected %0d", level, model_q.size()); end
    tests_run++; if (err !== model_err) begin tests_failed++; $display("FAIL ovf_err: got %b expected %b", err, model_err); end
    err_clr = 1'b1; step(1); err_clr = 1'b0; model_err = 2'b00;
    tests_run++; if (err !== model_err) begin tests_failed++; $display("FAIL err_clr: got %b expected %b", err, model_err); end
    tests_run++; if (wr_data !== model_q[0]) begin tests_failed++; $display("FAIL full_head: got %h expected %h", wr_data, model_q[0]); end
    cpu_write(8'h06, 1'b0, 1'b1);
    tests_run++; if (level !== 3'(model_q.size())) begin tests_failed++; $display("FAIL push_pop_full_level: got %0d expected %0d", level, model_q.size()); end
    tests_run++; if (err !== model_err) begin tests_failed++; $display("FAIL push_pop_full_err: got %b expected %b", err, model_err); end
    wr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++; if (wr_data !== model_q[0]) begin tests_failed++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, wr_data, model_q[0]); end
      step(1);
      void'(model_q.pop_front());
    end
    wr_ready = 1'b0;
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_drained: got %b expected 0", wr_valid); end
  endtask

  task automatic test_err_clr_race;
    for (int i = 0; i < DEPTH; i++) cpu_write(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cpu_write(8'h99, 1'b1, 1'b0);
    tests_run++; if (err !== model_err) begin tests_failed++; $display("FAIL clr_race_err: got %b expected %b", err, model_err); end
    err_clr = 1'b1; step(1); err_clr = 1'b0; model_err = 2'b00;
    tests_run++; if (err !== model_err) begin tests_failed++; $display("FAIL clr_race_cleared: got %b expected %b", err, model_err); end
    wr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++; if (wr_data !== model_q[0]) begin tests_failed++; $display("FAIL clr_race_drain[%0d]: got %h expected %h", i, wr_data, model_q[0]); end
      step(1);
      void'(model_q.pop_front());
    end
    wr_ready = 1'b0;
  endtask

  task automatic test_read_latch;
    int acks, ack_cycle;
    logic [7:0] b_ack, b_first, b_last, b_after;
    cpu_read(8'h11, 8'h22, 4, acks, ack_cycle, b_ack, b_first, b_last, b_after);
    tests_run++; if (acks !== 1) begin tests_failed++; $display("FAIL read_acks: got %0d expected 1", acks); end
    tests_run++; if (ack_cycle !== 2) begin tests_failed++; $display("FAIL read_ack_cycle: got %0d expected 2", ack_cycle); end
    tests_run++; if (b_ack !== BUS_IDLE) begin tests_failed++; $display("FAIL read_bus_at_ack: got %h expected %h", b_ack, BUS_IDLE); end
    tests_run++; if (b_first !== 8'h11) begin tests_failed++; $display("FAIL read_bus_first: got %h expected 11", b_first); end
    tests_run++; if (b_last !== 8'h11) begin tests_failed++; $display("FAIL read_bus_held: got %h expected 11", b_last); end
    tests_run++; if (b_after !== BUS_IDLE) begin tests_failed++; $display("FAIL read_bus_release: got %h expected %h", b_after, BUS_IDLE); end
  endtask

  task automatic test_conflict;
    int acks, ack_cycle;
    logic [7:0] b_ack, b_first, b_last, b_after;
    rd_data = 8'h5A; r = 1'b1; step(4);
    w = 1'b1; step(4); w = 1'b0; step(3);
    model_err[1] = 1'b1;
    $display("[TB] write during read level=%0d err=%b", level, err);
    tests_run++; if (level !== 3'(model_q.size())) begin tests_failed++; $display("FAIL conflict_no_push: got %0d expected %0d", level, model_q.size()); end
    tests_run++; if (err !== model_err) begin tests_failed++; $display("FAIL conflict_err_w: got %b expected %b", err, model_err); end
    tests_run++; if (data !== 8'h5A) begin tests_failed++; $display("FAIL conflict_bus: got %h expected 5a", data); end
    r = 1'b0; step(6);
    tests_run++; if (data !== BUS_IDLE) begin tests_failed++; $display("FAIL conflict_release: got %h expected %h", data, BUS_IDLE); end
    err_clr = 1'b1; step(1); err_clr = 1'b0; model_err = 2'b00;
    // w first: its edge pushes the idle bus value, then r rises while w is high.
    w = 1'b1; step(4);
    model_q.push_back(BUS_IDLE);
    tests_run++; if (data !== BUS_IDLE) begin tests_failed++; $display("FAIL bus_during_write: got %h expected %h", data, BUS_IDLE); end
    cpu_read(8'h3C, 8'h3C, 4, acks, ack_cycle, b_ack, b_first, b_last, b_after);
    model_err[1] = 1'b1;
    tests_run++; if (acks !== 1) begin tests_failed++; $display("FAIL conflict_read_ack: got %0d expected 1", acks); end
    tests_run++; if (b_first !== 8'h3C) begin tests_failed++; $display("FAIL conflict_read_bus: got %h expected 3c", b_first); end
    tests_run++; if (err !== model_err) begin tests_failed++; $display("FAIL conflict_err_r: got %b expected %b", err, model_err); end
    w = 1'b0; step(3);
    tests_run++; if (level !== 3'(model_q.size())) begin tests_failed++; $display("FAIL conflict_level: got %0d expected %0d", level, model_q.size()); end
    tests_run++; if (wr_data !== model_q[0]) begin tests_failed++; $display("FAIL conflict_word: got %h expected %h", wr_data, model_q[0]); end
    wr_ready = 1'b1; step(1); wr_ready = 1'b0;
    void'(model_q.pop_front());
    err_clr = 1'b1; step(1); err_clr = 1'b0; model_err = 2'b00;
  endtask

  task automatic test_reset_mid;
    int acks;
    cpu_write(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cpu_write(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    rd_data = 8'h77; r = 1'b1; step(4);
    w = 1'b1; step(4); w = 1'b0; step(3);
    rst = 1'b1; step(1); rst = 1'b0;
    model_q.delete(); model_err = 2'b00;
    $display("[TB] reset during read level=%0d", level);
    tests_run++; if (level !== 3'd0) begin tests_failed++; $display("FAIL rst_mid_level: got %0d expected 0", level); end
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_valid: got %b expected 0", wr_valid); end
    tests_run++; if (data !== BUS_IDLE) begin tests_failed++; $display("FAIL rst_mid_bus: got %h expected %h", data, BUS_IDLE); end
    tests_run++; if (err !== model_err) begin tests_failed++; $display("FAIL rst_mid_err: got %b expected %b", err, model_err); end
    acks = 0;
    for (int i = 0; i < 5; i++) begin step(1); if (rd_ack) acks++; end
    tests_run++; if (acks !== 1) begin tests_failed++; $display("FAIL rst_held_strobe_ack: got %0d expected 1", acks); end
    tests_run++; if (data !== 8'h77) begin tests_failed++; $display("FAIL rst_held_strobe_bus: got %h expected 77", data); end
    r = 1'b0; step(6);
  endtask

  task automatic test_random;
    int op, acks, ack_cycle;
    logic [7:0] v, b_ack, b_first, b_last, b_after;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: cpu_write(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        1: begin
          if (model_q.size() > 0) begin
            tests_run++; if (wr_data !== model_q[0]) begin tests_failed++; $display("FAIL rand_pop[%0d]: got %h expected %h", n, wr_data, model_q[0]); end
            wr_ready = 1'b1; step(1); wr_ready = 1'b0;
            $display("[TB] pop %h", model_q[0]);
            void'(model_q.pop_front());
          end else begin
            tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL rand_empty[%0d]: got %b expected 0", n, wr_valid); end
          end
        end
        2: begin
          v = 8'($urandom_range(1, 254));
          cpu_read(v, ~v, 3 + $urandom_range(0, 3), acks, ack_cycle, b_ack, b_first, b_last, b_after);
          tests_run++; if (acks !== 1) begin tests_failed++; $display("FAIL rand_read_ack[%0d]: got %0d expected 1", n, acks); end
          tests_run++; if (b_first !== v || b_last !== v) begin tests_failed++; $display("FAIL rand_read_bus[%0d]: got %h/%h expected %h", n, b_first, b_last, v); end
          tests_run++; if (b_after !== BUS_IDLE) begin tests_failed++; $display("FAIL rand_read_release[%0d]: got %h expected %h", n, b_after, BUS_IDLE); end
        end
        default: begin
          err_clr = 1'b1; step(1); err_clr = 1'b0; model_err = 2'b00;
          $display("[TB] err_clr");
        end
      endcase
      tests_run++; if (level !== 3'(model_q.size())) begin tests_failed++; $display("FAIL rand_level[%0d]: got %0d expected %0d", n, level, model_q.size()); end
      tests_run++; if (err !== model_err) begin tests_failed++; $display("FAIL rand_err[%0d]: got %b expected %b", n, err, model_err); end
    end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_err_clr_race();
    test_read_latch();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
